// File: rtl/pfm_cbuf_ctrl_pkg.sv
// Shared definitions for the prefetch-monitor circular buffer controller.
package pfm_cbuf_ctrl_pkg;

    localparam int PFM_CBUF_SIZE = 512;

    // Decode-stage stats record as stored in the buffer.
    typedef logic [63:0] pfm_cbuf_rec_t;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RD_WAIT = 1'b1
    } cbuf_state_e;

endpackage

// File: rtl/pfm_cbuf_ctrl.sv
// Circular-buffer controller: arbitrates push/pop onto one RAM port, owns the
// head/tail pointers and occupancy count, and sequences flushes.
module pfm_cbuf_ctrl
    import pfm_cbuf_ctrl_pkg::*;
#(
    parameter int Width   = $bits(pfm_cbuf_rec_t),
    parameter int Size    = PFM_CBUF_SIZE,
    parameter int PtrBits = $clog2(Size)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_valid,
    output logic               push_retry,
    input  logic [Width-1:0]   push_data,
    input  logic               pop_valid,
    output logic               pop_retry,
    output logic               popack_valid,
    input  logic               popack_retry,
    output logic [Width-1:0]   popack_data,
    input  logic               flush_valid,
    output logic               flush_retry,
    output logic               ram_req_valid,
    input  logic               ram_req_retry,
    output logic               ram_req_we,
    output logic [PtrBits-1:0] ram_req_pos,
    output logic [Width-1:0]   ram_req_data,
    input  logic               ram_ack_valid,
    output logic               ram_ack_retry,
    input  logic [Width-1:0]   ram_ack_data,
    output logic [PtrBits:0]   occupancy,
    output logic               full,
    output logic               empty
);

    localparam int CntBits = PtrBits + 1;

    logic [PtrBits-1:0] head_q, head_d;
    logic [PtrBits-1:0] tail_q, tail_d;
    logic [CntBits-1:0] count_q, count_d;
    logic               rr_q, rr_d;
    cbuf_state_e        state_q, state_d;

    logic push_elig, pop_elig, push_win, pop_win;
    logic push_go, pop_go, flush_go, ack_go, rd_wait;

    assign rd_wait   = (state_q == ST_RD_WAIT);
    assign full      = (count_q == CntBits'(Size));
    assign empty     = (count_q == '0);
    assign occupancy = count_q;

    // Eligibility is gated by reset so every request output holds its idle value while reset is low.
    assign push_elig = reset && push_valid && !full && !flush_valid;
    assign pop_elig  = reset && pop_valid && !empty && !rd_wait && !flush_valid;
    assign push_win  = push_elig && (!pop_elig || !rr_q);
    assign pop_win   = pop_elig && (!push_elig || rr_q);

    assign ram_req_valid = push_elig || pop_elig;
    assign ram_req_we    = push_win;
    assign ram_req_pos   = push_win ? head_q : tail_q;
    assign ram_req_data  = push_data;

    assign push_retry  = push_win ? ram_req_retry : 1'b1;
    assign pop_retry   = pop_win ? ram_req_retry : 1'b1;
    assign flush_retry = !reset || rd_wait;

    // An ack seen while no read is outstanding (e.g. straggler across reset) is dropped.
    assign popack_valid  = ram_ack_valid && rd_wait;
    assign popack_data   = ram_ack_data;
    assign ram_ack_retry = popack_retry;

    assign push_go  = push_win && !ram_req_retry;
    assign pop_go   = pop_win && !ram_req_retry;
    assign flush_go = flush_valid && !flush_retry;
    assign ack_go   = popack_valid && !popack_retry;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rr_d    = rr_q;
        state_d = state_q;

        if (flush_go) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            rr_d    = 1'b0;
        end else begin
            if (push_go) head_d = head_q + 1'b1;
            if (pop_go)  tail_d = tail_q + 1'b1;
            case ({push_go, pop_go})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // Priority passes to the loser only after a contested grant.
            if (push_elig && pop_elig && (push_go || pop_go)) rr_d = push_go;
        end

        if (pop_go)                state_d = ST_RD_WAIT;
        else if (rd_wait && ack_go) state_d = ST_RUN;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_pfm_cbuf_ctrl.sv
// Directed bench for pfm_cbuf_ctrl at Size=4 with a behavioural RAM and a data scoreboard.
module tb_pfm_cbuf_ctrl;

    localparam int W  = 64;
    localparam int S  = 4;
    localparam int PB = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push_valid = 1'b0, pop_valid = 1'b0, flush_valid = 1'b0;
    logic          popack_retry = 1'b0, ram_req_retry = 1'b0;
    logic [W-1:0]  push_data = '0;
    logic          push_retry, pop_retry, popack_valid, flush_retry;
    logic [W-1:0]  popack_data, ram_req_data, ram_ack_data;
    logic          ram_req_valid, ram_req_we, ram_ack_valid, ram_ack_retry;
    logic [PB-1:0] ram_req_pos;
    logic [PB:0]   occupancy;
    logic          full, empty;

    always #5 clk = ~clk;

    pfm_cbuf_ctrl #(.Width(W), .Size(S)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_retry(push_retry), .push_data(push_data),
        .pop_valid(pop_valid), .pop_retry(pop_retry),
        .popack_valid(popack_valid), .popack_retry(popack_retry), .popack_data(popack_data),
        .flush_valid(flush_valid), .flush_retry(flush_retry),
        .ram_req_valid(ram_req_valid), .ram_req_retry(ram_req_retry), .ram_req_we(ram_req_we),
        .ram_req_pos(ram_req_pos), .ram_req_data(ram_req_data),
        .ram_ack_valid(ram_ack_valid), .ram_ack_retry(ram_ack_retry), .ram_ack_data(ram_ack_data),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    // Behavioural single-port RAM: read data returns the cycle after the request and is held until taken.
    logic [W-1:0] mem [S];
    logic         ack_pending;
    logic [W-1:0] ack_data;
    assign ram_ack_valid = ack_pending;
    assign ram_ack_data  = ack_data;

    always @(posedge clk)
        if (reset && ram_req_valid && !ram_req_retry && ram_req_we) mem[ram_req_pos] <= ram_req_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_pending <= 1'b0;
            ack_data    <= '0;
        end else begin
            if (ack_pending && !ram_ack_retry) ack_pending <= 1'b0;
            if (ram_req_valid && !ram_req_retry && !ram_req_we) begin
                ack_pending <= 1'b1;
                ack_data    <= mem[ram_req_pos];
            end
        end
    end

    int           n_checks = 0;
    int           n_fail = 0;
    int           exp_head = 0, exp_tail = 0, exp_count = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [W-1:0] d);
        push_valid = 1'b1;
        push_data  = d;
        #1;
        check("push_retry", push_retry, 0);
        check("push_we", ram_req_we, 1);
        check("push_pos", ram_req_pos, exp_head);
        tick();
        push_valid = 1'b0;
        exp_q.push_back(d);
        exp_head = (exp_head + 1) % S;
        exp_count++;
        check("occ_after_push", occupancy, exp_count);
    endtask

    task automatic issue_pop();
        pop_valid = 1'b1;
        #1;
        check("pop_retry", pop_retry, 0);
        check("pop_we", ram_req_we, 0);
        check("pop_pos", ram_req_pos, exp_tail);
        tick();
        pop_valid = 1'b0;
        exp_tail = (exp_tail + 1) % S;
        exp_count--;
        check("occ_after_pop", occupancy, exp_count);
    endtask

    task automatic take_ack();
        logic [W-1:0] e;
        int k = 0;
        while (!popack_valid && k < 8) begin
            tick();
            k++;
        end
        check("ack_arrived", popack_valid, 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("popack_data", popack_data, e);
        tick();
    endtask

    task automatic contend(input logic [W-1:0] d);
        push_valid = 1'b1;
        pop_valid  = 1'b1;
        push_data  = d;
        #1;
        check("cont_push_wins", push_retry, 0);
        check("cont_pop_loses", pop_retry, 1);
        check("cont_push_pos", ram_req_pos, exp_head);
        tick();
        exp_q.push_back(d);
        exp_head = (exp_head + 1) % S;
        exp_count++;
        #1;
        check("cont_push_loses", push_retry, 1);
        check("cont_pop_wins", pop_retry, 0);
        check("cont_pop_we", ram_req_we, 0);
        check("cont_pop_pos", ram_req_pos, exp_tail);
        tick();
        push_valid = 1'b0;
        pop_valid  = 1'b0;
        exp_tail = (exp_tail + 1) % S;
        exp_count--;
        take_ack();
        check("cont_occ", occupancy, 2);
    endtask

    initial begin
        // Reset, with requests already asserted.
        push_valid  = 1'b1;
        pop_valid   = 1'b1;
        flush_valid = 1'b1;
        #12;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_occ", occupancy, 0);
        check("rst_ram_req_valid", ram_req_valid, 0);
        check("rst_popack_valid", popack_valid, 0);
        check("rst_push_retry", push_retry, 1);
        check("rst_pop_retry", pop_retry, 1);
        check("rst_flush_retry", flush_retry, 1);
        push_valid  = 1'b0;
        pop_valid   = 1'b0;
        flush_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // RAM backpressure stalls the winning push.
        ram_req_retry = 1'b1;
        push_valid    = 1'b1;
        push_data     = 64'hDEAD;
        #1;
        check("ramstall_req_valid", ram_req_valid, 1);
        check("ramstall_push_retry", push_retry, 1);
        tick();
        check("ramstall_occ", occupancy, 0);
        ram_req_retry = 1'b0;
        push_valid    = 1'b0;

        // Fill to full, then push at full.
        for (int i = 0; i < S; i++) do_push(64'hA0 + 64'(i));
        check("fill_full", full, 1);
        push_valid = 1'b1;
        #1;
        check("full_push_retry", push_retry, 1);
        check("full_no_req", ram_req_valid, 0);
        tick();
        check("full_occ", occupancy, S);
        push_valid = 1'b0;

        // Drain, then pop at empty.
        for (int i = 0; i < S; i++) begin
            issue_pop();
            take_ack();
        end
        check("drain_empty", empty, 1);
        pop_valid = 1'b1;
        #1;
        check("empty_pop_retry", pop_retry, 1);
        check("empty_no_req", ram_req_valid, 0);
        tick();
        pop_valid = 1'b0;

        // Contention with occupancy 2: push and pop alternate.
        do_push(64'hE0);
        do_push(64'hF0);
        contend(64'h60);
        contend(64'h70);

        // Wrap both pointers.
        do_push(64'h90);
        do_push(64'h91);
        check("wrap_full", full, 1);
        for (int i = 0; i < 3; i++) begin
            issue_pop();
            take_ack();
        end

        // Popped-record backpressure with a concurrent push.
        do_push(64'hB0);
        issue_pop();
        popack_retry = 1'b1;
        pop_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_popack_valid", popack_valid, 1);
            check("bp_popack_data", popack_data, exp_q[0]);
            check("bp_pop_retry", pop_retry, 1);
            if (i == 2) begin
                push_valid = 1'b1;
                push_data  = 64'hB1;
                #1;
                check("bp_push_granted", push_retry, 0);
                check("bp_push_pos", ram_req_pos, exp_head);
                tick();
                push_valid = 1'b0;
                exp_q.push_back(64'hB1);
                exp_head = (exp_head + 1) % S;
                exp_count++;
            end else begin
                tick();
            end
        end
        popack_retry = 1'b0;
        #1;
        check("bp_release_pop_retry", pop_retry, 1);
        check("bp_release_data", popack_data, exp_q.pop_front());
        tick();
        #1;
        check("bp_next_pop_granted", pop_retry, 0);
        check("bp_next_pop_pos", ram_req_pos, exp_tail);
        tick();
        pop_valid = 1'b0;
        exp_tail = (exp_tail + 1) % S;
        exp_count--;
        check("bp_occ", occupancy, exp_count);

        // Flush while a read is outstanding.
        popack_retry = 1'b1;
        flush_valid  = 1'b1;
        push_valid   = 1'b1;
        push_data    = 64'hCC;
        #1;
        check("flush_wait_retry", flush_retry, 1);
        check("flush_blocks_push", push_retry, 1);
        check("flush_blocks_req", ram_req_valid, 0);
        tick();
        check("flush_wait_retry2", flush_retry, 1);
        popack_retry = 1'b0;
        #1;
        check("flush_ack_data", popack_data, exp_q.pop_front());
        tick();
        #1;
        check("flush_accept_retry", flush_retry, 0);
        check("flush_accept_no_req", ram_req_valid, 0);
        tick();
        flush_valid = 1'b0;
        push_valid  = 1'b0;
        exp_q.delete();
        exp_head  = 0;
        exp_tail  = 0;
        exp_count = 0;
        check("flush_occ", occupancy, 0);
        check("flush_empty", empty, 1);
        do_push(64'hD0);
        issue_pop();
        take_ack();

        // Asynchronous reset in the middle of a push.
        do_push(64'hD1);
        push_valid = 1'b1;
        push_data  = 64'hD2;
        #1;
        check("pre_rst_req_valid", ram_req_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_ram_req_valid", ram_req_valid, 0);
        check("arst_push_retry", push_retry, 1);
        check("arst_pop_retry", pop_retry, 1);
        check("arst_flush_retry", flush_retry, 1);
        check("arst_occ", occupancy, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_popack_valid", popack_valid, 0);
        push_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pfm_cbuf_ctrl.md
Name: pfm_cbuf_ctrl

Overview:
Controller for the prefetch-monitor circular buffer, a 512-entry single-port RAM that holds decode-stage stats records.
- Shares the one RAM port between a push requester (decode stats from the dec fflop) and a pop requester (oldest record, consumed at retire or by the predictor).
- Owns the head and tail pointers, the occupancy count, arbitration and flush sequencing.
- Sits inside pfmonitor between the input fflops and the ram_1port_fast instance.

Parameters:
Width, 64, bits per buffer record ($bits of the decode stats record at instantiation)
Size, 512, number of entries; power of two, >= 2
PtrBits, `log2(Size), pointer width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
push_valid  in  1  push request
push_retry  out  1  push backpressure
push_data  in  Width  record to append
pop_valid  in  1  pop request (remove oldest record)
pop_retry  out  1  pop backpressure
popack_valid  out  1  popped record valid
popack_retry  in  1  popped-record backpressure
popack_data  out  Width  popped record
flush_valid  in  1  flush request (discard all records)
flush_retry  out  1  flush backpressure
ram_req_valid  out  1  RAM request
ram_req_retry  in  1  RAM backpressure
ram_req_we  out  1  1 = write, 0 = read
ram_req_pos  out  PtrBits  RAM address
ram_req_data  out  Width  write data
ram_ack_valid  in  1  RAM read data valid
ram_ack_retry  out  1  RAM ack backpressure
ram_ack_data  in  Width  RAM read data
occupancy  out  PtrBits+1  records held, 0..Size
full  out  1  occupancy == Size
empty  out  1  occupancy == 0

Behaviour:
- Handshake: a transfer happens on a channel when valid=1 and retry=0 in the same cycle. Retry may depend combinationally on valid inputs. Valid must not depend on retry.
- Reset (reset=0, asynchronous):
  - head=0, tail=0, count=0, rr=0, state=RUN.
  - Reset outputs: empty=1, full=0, occupancy=0, ram_req_valid=0, popack_valid=0, push_retry=1, pop_retry=1, flush_retry=1.
- State machine (two states):
  - RUN: no read outstanding.
  - RD_WAIT: one RAM read issued, its ack not yet delivered.
- Eligibility:
  - Push eligible: push_valid && !full && !flush_valid.
  - Pop eligible: pop_valid && !empty && state==RUN && !flush_valid.
- Arbitration, one RAM op per cycle:
  - Only one requester eligible: it wins.
  - Both eligible: rr selects (rr=0 push wins, rr=1 pop wins).
  - rr toggles to the loser only on a granted cycle where both were eligible.
- ram_req_valid = any requester eligible. The grant completes only if ram_req_retry=0.
- Loser retry: the losing requester, and any requester not eligible, sees retry=1. The winner's retry is ram_req_retry.
- Push accept:
  - Outputs: we=1, pos=head, data=push_data.
  - Next cycle: head=head+1 (mod Size), count+1.
- Pop accept:
  - Outputs: we=0, pos=tail.
  - Next cycle: tail=tail+1 (mod Size), count-1, state=RD_WAIT.
- Pointer wrap: head and tail wrap from Size-1 to 0. Full and empty come from count only, never from pointer compare.
- Ack path is combinational pass-through: popack_valid=ram_ack_valid, popack_data=ram_ack_data, ram_ack_retry=popack_retry.
  - RD_WAIT -> RUN on the cycle the popack handshake completes.
  - A new pop cannot issue in that same cycle; pops issue from RUN only.
- Push in RD_WAIT: allowed (the RAM accepts a write while a read ack is pending).
- Flush:
  - flush_retry = (state==RD_WAIT).
  - On accept: next cycle head=tail=count=0 and rr=0.
  - flush_valid blocks push and pop grants in the accepting cycle. Flush has priority over both.
- Occupancy invariant: count stays within 0..Size. No push at full, no pop at empty; both are enforced by eligibility.
- Reset mid-read: any in-flight RAM ack after reset deasserts is dropped. The RAM shares the same reset, so no ack is expected.

Decomposition:
- Shared package (scmem.vh): PFM_CBUF_SIZE=512 and the buffer record typedef (alias of I_coretopfm_dec_type).
- No sub-module. The push/pop arbiter is a few lines inline; a separate rr arbiter module is not warranted for two requesters.

Test Plan:
- Push only, Size=4: push records A,B,C,D -> RAM writes at pos 0,1,2,3; full=1 and occupancy=4 after D; a 5th push sees push_retry=1 and no RAM request.
- Pop after fill: pop 4 times -> reads at pos 0..3, popack_data A..D in order; empty=1 after the 4th; pop on empty gets pop_retry=1.
- Contention: push and pop both held valid with occupancy=2 -> grants alternate push, pop, push, ... (rr); one RAM op per cycle; occupancy returns to 2 after each pop/push pair.
- Wrap: 6 pushes interleaved with 4 pops at Size=4 -> head wraps to 2 and tail to 0 (pos sequence 0,1,2,3,0,1); popped data preserves FIFO order.
- Backpressure: popack_retry=1 for 5 cycles after a pop -> popack_valid held, data stable, pop_retry=1 throughout; a concurrent push is still granted; the next pop is granted only in the cycle after the ack handshake.
- Flush during RD_WAIT: flush_retry=1 until the ack is consumed, then flush is accepted -> occupancy=0, head=tail=0; async reset asserted mid-push -> all outputs take reset values immediately.
